// File: rtl/br_ctrl_pkg.sv
// Shared branch-unit definitions: funct3 encodings, BHT counter type and saturating helpers.
package br_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_t;

  function automatic bht_t sat_inc(input bht_t v);
    return (v == ST) ? ST : bht_t'(v + 2'd1);
  endfunction

  function automatic bht_t sat_dec(input bht_t v);
    return (v == SNT) ? SNT : bht_t'(v - 2'd1);
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB with per-entry 2-bit BHT: one combinational lookup port and one
// synchronous resolve-update port.
module btb_table
  import br_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = $clog2(ENTRIES),
  localparam int unsigned TAG_W  = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic        wr_taken,
  input  logic        wr_jmp,
  input  logic [31:0] wr_target
);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  bht_t             bht_q   [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_match;
  logic             unused_pc_bits;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[31:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  // Lookup sees pre-update state; a same-cycle write lands at the edge.
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken  = rd_hit && bht_q[rd_idx][1];
  assign rd_target = rd_hit ? tgt_q[rd_idx] : 32'd0;

  assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        bht_q[i]   <= WNT;
      end
    end else if (wr_en) begin
      if (wr_taken) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= wr_tag;
        tgt_q[wr_idx]   <= wr_target;
        bht_q[wr_idx]   <= wr_jmp ? ST : sat_inc(bht_q[wr_idx]);
      end else if (wr_match) begin
        // Not-taken only trains an entry that actually belongs to this branch.
        bht_q[wr_idx] <= sat_dec(bht_q[wr_idx]);
      end
    end
  end

endmodule

// File: rtl/br_ctrl.sv
// EX-stage branch/jump resolution, misprediction redirect and performance counters,
// with BTB/BHT lookup for the fetch stage.
module br_ctrl
  import br_ctrl_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_br,
  input  logic             ex_is_jmp,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic             br_less,
  input  logic             br_equal,
  output logic             br_unsigned,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_miss_cnt
);

  logic             legal_f3, br_cond, actual_taken, resolve, mispredict;
  logic             if_hit;
  logic [CNT_W-1:0] br_cnt_q, miss_cnt_q;

  assign br_unsigned = ex_funct3[1];

  always_comb begin
    legal_f3 = 1'b1;
    br_cond  = 1'b0;
    unique case (ex_funct3)
      F3_BEQ:           br_cond = br_equal;
      F3_BNE:           br_cond = !br_equal;
      F3_BLT, F3_BLTU:  br_cond = br_less;
      F3_BGE, F3_BGEU:  br_cond = !br_less;
      default:          legal_f3 = 1'b0;
    endcase
  end

  assign actual_taken = ex_is_jmp || br_cond;
  assign resolve      = ex_valid && !ex_stall && (ex_is_jmp || (ex_is_br && legal_f3));
  assign mispredict   = actual_taken ? (!ex_pred_taken || (ex_pred_target != ex_target))
                                     : ex_pred_taken;

  assign redirect    = rst_n && resolve && mispredict;
  assign flush       = redirect;
  assign redirect_pc = actual_taken ? ex_target : ex_pc + 32'd4;

  btb_table #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (if_pc),
    .rd_hit    (if_hit),
    .rd_taken  (if_pred_taken),
    .rd_target (if_pred_target),
    .wr_en     (resolve),
    .wr_pc     (ex_pc),
    .wr_taken  (actual_taken),
    .wr_jmp    (ex_is_jmp),
    .wr_target (ex_target)
  );

  logic unused_hit;
  assign unused_hit = if_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (resolve) begin
      br_cnt_q   <= br_cnt_q + 1'b1;
      miss_cnt_q <= miss_cnt_q + CNT_W'(redirect);
    end
  end

  assign perf_br_cnt   = br_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_br_ctrl.sv
// Directed bench for br_ctrl: a per-cycle reference model plus hand-computed spot checks.
module tb_br_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid, ex_stall, ex_is_br, ex_is_jmp;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken, br_less, br_equal;
  logic        br_unsigned, redirect, flush;
  logic [31:0] redirect_pc, perf_br_cnt, perf_miss_cnt;

  int compared = 0;
  int mismatched = 0;

  br_ctrl #(.BTB_ENTRIES(16), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_br       (ex_is_br),
    .ex_is_jmp      (ex_is_jmp),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .br_less        (br_less),
    .br_equal       (br_equal),
    .br_unsigned    (br_unsigned),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .perf_br_cnt    (perf_br_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: table of entries as plain integers.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_bht   [16];
  logic [31:0] m_br, m_miss;

  function automatic bit m_legal();
    return !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
  endfunction

  function automatic bit m_taken();
    if (ex_is_jmp) return 1'b1;
    case (ex_funct3)
      3'd0: return br_equal;
      3'd1: return !br_equal;
      3'd4, 3'd6: return br_less;
      3'd5, 3'd7: return !br_less;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_resolve();
    return ex_valid && !ex_stall && (ex_is_jmp || (ex_is_br && m_legal()));
  endfunction

  function automatic bit m_redirect();
    bit wrong;
    if (m_taken()) wrong = !ex_pred_taken || (ex_pred_target != ex_target);
    else           wrong = ex_pred_taken;
    return m_resolve() && wrong;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_bht[i] = 1;
      end
      m_br = 32'd0; m_miss = 32'd0;
    end else if (m_resolve()) begin
      int          i;
      int unsigned t;
      i = int'((ex_pc >> 2) % 16);
      t = ex_pc >> 6;
      m_br = m_br + 32'd1;
      if (m_redirect()) m_miss = m_miss + 32'd1;
      if (m_taken()) begin
        m_valid[i] = 1'b1; m_tag[i] = t; m_tgt[i] = ex_target;
        m_bht[i] = ex_is_jmp ? 3 : ((m_bht[i] < 3) ? m_bht[i] + 1 : 3);
      end else if (m_valid[i] && m_tag[i] == t) begin
        m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("model_redirect_in_reset", {31'd0, redirect}, 32'd0);
      chk("model_flush_in_reset", {31'd0, flush}, 32'd0);
    end else begin
      int i;
      bit hit;
      i = int'((if_pc >> 2) % 16);
      hit = m_valid[i] && (m_tag[i] == (if_pc >> 6));
      chk("model_br_unsigned", {31'd0, br_unsigned}, {31'd0, ex_funct3[1]});
      chk("model_redirect", {31'd0, redirect}, {31'd0, m_redirect()});
      chk("model_flush", {31'd0, flush}, {31'd0, m_redirect()});
      chk("model_redirect_pc", redirect_pc, m_taken() ? ex_target : ex_pc + 32'd4);
      chk("model_pred_taken", {31'd0, if_pred_taken}, {31'd0, hit && (m_bht[i] >= 2)});
      chk("model_pred_target", if_pred_target, hit ? m_tgt[i] : 32'd0);
      chk("model_br_cnt", perf_br_cnt, m_br);
      chk("model_miss_cnt", perf_miss_cnt, m_miss);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit br, input bit jmp, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit pt,
                        input logic [31:0] ptgt, input bit lt, input bit eq);
    ex_valid = 1'b1; ex_stall = 1'b0; ex_is_br = br; ex_is_jmp = jmp; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    br_less = lt; br_equal = eq;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_stall = 1'b0; ex_is_br = 1'b0; ex_is_jmp = 1'b0;
    ex_pred_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h100;
    ex_funct3 = 3'd0; ex_pc = 32'd0; ex_target = 32'd0; ex_pred_target = 32'd0;
    br_less = 1'b0; br_equal = 1'b0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    #2;
    chk("reset_br_cnt", perf_br_cnt, 32'd0);
    chk("reset_pred", {31'd0, if_pred_taken}, 32'd0);

    // 1: BEQ taken, unpredicted; same-cycle lookup sees old state.
    set_ex(1, 0, 3'b000, 32'h100, 32'h80, 0, 32'd0, 0, 1);
    #2;
    chk("t1_redirect", {31'd0, redirect}, 32'd1);
    chk("t1_redirect_pc", redirect_pc, 32'h80);
    chk("t1_old_pred", {31'd0, if_pred_taken}, 32'd0);
    tick(); idle(); #2;
    chk("t1_new_pred", {31'd0, if_pred_taken}, 32'd1);
    chk("t1_new_target", if_pred_target, 32'h80);

    // 2: BLTU (1 < 0xFFFFFFFF unsigned) then BLT (1 < -1 false).
    set_ex(1, 0, 3'b110, 32'h408, 32'h480, 0, 32'd0, 1, 0);
    #2;
    chk("t2_bltu_unsigned", {31'd0, br_unsigned}, 32'd1);
    chk("t2_bltu_redirect_pc", redirect_pc, 32'h480);
    tick();
    set_ex(1, 0, 3'b100, 32'h408, 32'h480, 0, 32'd0, 0, 0);
    #2;
    chk("t2_blt_unsigned", {31'd0, br_unsigned}, 32'd0);
    chk("t2_blt_redirect", {31'd0, redirect}, 32'd0);
    chk("t2_blt_redirect_pc", redirect_pc, 32'h40C);
    tick();

    // 3: JAL with wrong predicted target.
    set_ex(0, 1, 3'b000, 32'h200, 32'h340, 1, 32'h300, 0, 0);
    #2;
    chk("t3_redirect_pc", redirect_pc, 32'h340);
    tick(); idle(); if_pc = 32'h200; #2;
    chk("t3_btb_target", if_pred_target, 32'h340);
    chk("t3_btb_taken", {31'd0, if_pred_taken}, 32'd1);
    if_pc = 32'h100; #1;
    chk("t3_evicted", if_pred_target, 32'd0);
    chk("t3_br_cnt", perf_br_cnt, 32'd4);
    chk("t3_miss_cnt", perf_miss_cnt, 32'd3);

    // 4: BNE mispredict held by a 3-cycle stall.
    set_ex(1, 0, 3'b001, 32'h40C, 32'h4A0, 0, 32'd0, 0, 0);
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t4_stalled_redirect", {31'd0, redirect}, 32'd0);
      tick();
    end
    ex_stall = 1'b0; #2;
    chk("t4_redirect", {31'd0, redirect}, 32'd1);
    chk("t4_redirect_pc", redirect_pc, 32'h4A0);
    tick(); idle(); #2;
    chk("t4_br_cnt", perf_br_cnt, 32'd5);
    chk("t4_miss_cnt", perf_miss_cnt, 32'd4);

    // 5: saturate up, then down, then illegal funct3 does nothing.
    if_pc = 32'h414;
    set_ex(1, 0, 3'b000, 32'h414, 32'h500, 1, 32'h500, 0, 1);
    for (int k = 0; k < 4; k++) tick();
    ex_valid = 1'b0; #2;
    chk("t5_sat_taken", {31'd0, if_pred_taken}, 32'd1);
    chk("t5_sat_target", if_pred_target, 32'h500);
    set_ex(1, 0, 3'b000, 32'h414, 32'h500, 0, 32'd0, 0, 0);
    tick(); #1;
    chk("t5_after1_nt", {31'd0, if_pred_taken}, 32'd1);
    tick(); #1;
    chk("t5_after2_nt", {31'd0, if_pred_taken}, 32'd0);
    tick(); tick();
    set_ex(1, 0, 3'b010, 32'h414, 32'h500, 1, 32'h500, 0, 1);
    #2;
    chk("t5_illegal_redirect", {31'd0, redirect}, 32'd0);
    tick(); tick(); idle(); #2;
    chk("t5_illegal_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("t5_br_cnt", perf_br_cnt, 32'd13);

    // PC+4 wraps at the top of the address space.
    set_ex(1, 0, 3'b000, 32'hFFFFFFFC, 32'h10, 1, 32'h10, 0, 0);
    #2;
    chk("wrap_redirect", {31'd0, redirect}, 32'd1);
    chk("wrap_redirect_pc", redirect_pc, 32'd0);
    tick();

    // 6: same-index lookup/update, then reset in the middle of an update.
    if_pc = 32'h418;
    set_ex(1, 0, 3'b000, 32'h418, 32'h600, 0, 32'd0, 0, 1);
    #2;
    chk("t6_old_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("t6_old_target", if_pred_target, 32'd0);
    tick(); idle(); #2;
    chk("t6_new_pred", {31'd0, if_pred_taken}, 32'd1);
    chk("t6_new_target", if_pred_target, 32'h600);
    set_ex(1, 0, 3'b000, 32'h418, 32'h700, 0, 32'd0, 0, 1);
    rst_n = 1'b0; #2;
    chk("t6_rst_redirect", {31'd0, redirect}, 32'd0);
    tick(); rst_n = 1'b1; idle(); #2;
    chk("t6_rst_br_cnt", perf_br_cnt, 32'd0);
    chk("t6_rst_miss_cnt", perf_miss_cnt, 32'd0);
    chk("t6_rst_target", if_pred_target, 32'd0);
    set_ex(1, 0, 3'b000, 32'h418, 32'h600, 0, 32'd0, 0, 1);
    tick(); idle(); #2;
    chk("t6_bht_weak_nt", {31'd0, if_pred_taken}, 32'd1);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
